// File: rtl/green_pkg.sv
// Shared constants for the green fetch stage: opcodes and the fetch state encoding.
// Purely declarative; no timing or backpressure of its own.
package green_pkg;

  localparam logic [3:0] OPC_LD   = 4'h0;
  localparam logic [3:0] OPC_ST   = 4'h1;
  localparam logic [3:0] OPC_INC  = 4'h2;
  localparam logic [3:0] OPC_BR   = 4'h3;
  localparam logic [3:0] OPC_HALT = 4'hF;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_FETCH = 2'd0;
  localparam logic [STATE_W-1:0] S_ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] S_HALT  = 2'd2;

endpackage

// File: rtl/green_pc_reg.sv
// Program counter register: sync reset to RESET_PC, load beats increment.
// Latency: new value visible the cycle after load/inc; no backpressure (enables only).
// Increment wraps modulo 2^ADDR_W.
module green_pc_reg #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/green_fetch.sv
// Instruction fetch: holds pc, fetches over req/ack, presents one instruction to the decoder.
// Latency: ins_valid one cycle after imem_ack; stall holds ins/pc; at most 1 instr per 2 cycles.
// Optional HALT support is compiled in with GREEN_FETCH_HALT_EN.
module green_fetch
  import green_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OPC = OPC_HALT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_tgt,
  output logic [DATA_W-1:0] ins,
  output logic              ins_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               consume;
  logic               halt_hit;
  logic               halting;
  logic               pc_load;
  logic               pc_inc;

  assign consume  = (state == S_ISSUE) && !stall;
  assign halt_hit = (ins[DATA_W-1 -: 4] == HALT_OPC);

`ifdef GREEN_FETCH_HALT_EN
  assign halting = consume && halt_hit;
`else
  logic unused_halt;
  assign unused_halt = halt_hit;
  assign halting     = 1'b0;
`endif

  // A halting instruction leaves pc pointing at itself.
  assign pc_load = consume && br_taken && !halting;
  assign pc_inc  = consume && !br_taken && !halting;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (imem_ack) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          state_nxt = halting ? S_HALT : S_FETCH;
        end
      end
`ifdef GREEN_FETCH_HALT_EN
      S_HALT:  state_nxt = S_HALT;
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req = (state == S_FETCH) && !rst;
`ifdef GREEN_FETCH_HALT_EN
    halted   = (state == S_HALT);
`else
    halted   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ins       <= '0;
      ins_valid <= 1'b0;
    end else if ((state == S_FETCH) && imem_ack) begin
      ins       <= imem_rdata;
      ins_valid <= 1'b1;
    end else if (consume) begin
      ins_valid <= 1'b0;
    end
  end

  green_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (br_tgt),
    .pc       (pc)
  );

  assign imem_addr = pc;

endmodule

// File: tb/tb_green_fetch.sv
// Scoreboarded bench for green_fetch: bench acts as instruction memory and decoder.
module tb_green_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_tgt = '0;
  logic [15:0] ins;
  logic        ins_valid;
  logic [15:0] pc;
  logic        halted;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_pc;

  green_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_tgt     (br_tgt),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .pc         (pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One full fetch/issue transaction; the model pc advances by the decoder's decision.
  task automatic do_txn(input logic [15:0] w, input int d, input int s,
                        input logic br, input logic [15:0] tgt);
    int n = 0;
    while (!imem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      chk("req_timeout", 32'(imem_req), 32'd1);
      return;
    end
    chk("fetch_addr", 32'(imem_addr), 32'(model_pc));
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", 32'(imem_addr), 32'(model_pc));
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    exp_q.push_back(w);
    @(negedge clk);
    chk("issue_valid", 32'(ins_valid), 32'd1);
    chk("issue_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < s; i++) begin
      stall      = 1'b1;
      br_taken   = 1'($urandom);
      br_tgt     = 16'($urandom);
      imem_ack   = 1'($urandom);
      imem_rdata = 16'($urandom);
      @(negedge clk);
      chk("stall_ins", 32'(ins), 32'(w));
      chk("stall_valid", 32'(ins_valid), 32'd1);
      chk("stall_pc", 32'(pc), 32'(model_pc));
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    stall    = 1'b0;
    imem_ack = 1'b0;
    br_taken = br;
    br_tgt   = tgt;
    @(negedge clk);
    br_taken = 1'b0;
    chk("consumed_valid", 32'(ins_valid), 32'd0);
    model_pc = br ? tgt : model_pc + 16'd1;
  endtask

  initial begin
    fork
      begin : monitor
        logic prev = 1'b0;
        forever begin
          @(negedge clk);
          if (rst) begin
            prev = 1'b0;
          end else begin
            if (ins_valid && !prev) begin
              if (exp_q.size() == 0) begin
                chk("unexpected_ins", 32'(ins), 32'hffffffff);
              end else begin
                chk("ins_data", 32'(ins), 32'(exp_q.pop_front()));
              end
            end
            prev = ins_valid;
          end
        end
      end
      begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
      end
    join_none

    model_pc = 16'h0000;
    repeat (2) begin
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", 32'(imem_addr), 32'h0000);
    chk("post_rst_valid", 32'(ins_valid), 32'd0);
    chk("post_rst_halted", 32'(halted), 32'd0);
    chk("post_rst_ins", 32'(ins), 32'h0000);

    do_txn(16'h0A00, 2, 0, 1'b0, 16'h0000);
    do_txn(16'h2000, 0, 3, 1'b0, 16'h0000);
    do_txn(16'h0123, 1, 0, 1'b0, 16'h0000);
    do_txn(16'h1000, 0, 1, 1'b0, 16'h0000);
    do_txn(16'h3000, 0, 0, 1'b1, 16'h0020);
    do_txn(16'h3000, 0, 0, 1'b1, 16'hFFFF);
    do_txn(16'h2000, 0, 2, 1'b0, 16'h0000);
    do_txn(16'h3000, 1, 0, 1'b1, 16'h0000);
    do_txn(16'h3000, 0, 0, 1'b1, 16'h0007);
    do_txn(16'hF000, 1, 0, 1'b0, 16'h0000);
`ifdef GREEN_FETCH_HALT_EN
    chk("halt_flag", 32'(halted), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_valid", 32'(ins_valid), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_pc = 16'h0000;
    @(negedge clk);
    chk("halt_cleared", 32'(halted), 32'd0);
`else
    chk("no_halt_flag", 32'(halted), 32'd0);
`endif
    do_txn(16'h0555, 0, 0, 1'b0, 16'h0000);

    for (int t = 0; t < 300; t++) begin
      logic [15:0] w;
      logic        br;
      w  = 16'($urandom_range(0, 32'hEFFF));
      br = ($urandom_range(0, 3) == 0);
      do_txn(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), br, 16'($urandom));
      if (t == 150) begin
        // Abandon an outstanding request with reset; the next fetch restarts at zero.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        rst = 1'b0;
        model_pc = 16'h0000;
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
